cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the team's fixed 16-bit two-level CLA, generalised in operand width, lookahead group size and pipeline depth.
- Adds subtract mode, signed-overflow detection and a valid/ready stream interface.
- Sits between operand-fetch and writeback in the datapath; accepts one operation per cycle.

---
 rtl/cla_pkg.sv | 29 ++
 rtl/cla_group.sv | 42 ++++
 rtl/cla_pipe_adder.sv | 163 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared configuration helpers and operation encoding for the pipelined CLA.
// Contents:
//   OP_ADD / OP_SUB       encoding of the in_sub control bit
//   slice_width()         bits added per pipeline stage
//   groups_per_slice()    lookahead groups inside one stage slice
//   cfg_ok()              legality check: WIDTH must be a multiple of STAGES*GROUP
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic int unsigned groups_per_slice(input int unsigned width,
                                                   input int unsigned stages,
                                                   input int unsigned group);
    return width / (stages * group);
  endfunction

  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned group,
                                input int unsigned stages);
    return (stages != 0) && (group != 0) && ((width % (stages * group)) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit adder block producing the sum plus the group
// propagate/generate terms consumed by the slice lookahead unit.
// Ports:
//   a, b  in   GROUP  operand bits of this group
//   cin   in   1      carry into the group's LSB
//   sum   out  GROUP  a + b + cin (low GROUP bits)
//   p     out  1      group propagate (all bit propagates set)
//   g     out  1      group generate (carry out with cin = 0)
module cla_group import cla_pkg::*; #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] bp;
  logic [GROUP-1:0] bg;

  assign bp = a ^ b;
  assign bg = a & b;

  // Bit-level carry chain for the sum; group P/G are independent of cin.
  always_comb begin
    logic cy;
    logic gacc;
    sum  = '0;
    cy   = cin;
    gacc = 1'b0;
    for (int i = 0; i < int'(GROUP); i++) begin
      sum[i] = bp[i] ^ cy;
      cy     = bg[i] | (bp[i] & cy);
      gacc   = bg[i] | (bp[i] & gacc);
    end
    p = &bp;
    g = gacc;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream
// interface. Stage k adds bit slice k using the carry registered by stage
// k-1; operands ride ahead and finished sum slices ride behind so the whole
// word leaves the last stage aligned. Latency is STAGES cycles, one op/cycle.
// Optional feature macro: CLA_PIPE_SAT_EN (saturate out_sum on signed overflow).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake
//   in_a, in_b           operands (WIDTH)
//   in_cin               carry-in, ignored when subtracting
//   in_sub               1 = A-B, 0 = A+B+cin
//   out_valid/out_ready  result handshake
//   out_sum              result (WIDTH)
//   out_cout             carry out of MSB (subtract: 1 = no borrow)
//   out_ovf              two's-complement signed overflow
module cla_pipe_adder import cla_pkg::*; #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned S   = slice_width(WIDTH, STAGES);
  localparam int unsigned GPS = groups_per_slice(WIDTH, STAGES, GROUP);
  localparam int unsigned L   = STAGES - 1;

  if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_cfg_err
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP");
  end

  // Stage registers
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  // Stage inputs and combinational stage results
  logic             st_v  [STAGES];
  logic [WIDTH-1:0] st_a  [STAGES];
  logic [WIDTH-1:0] st_b  [STAGES];
  logic [WIDTH-1:0] st_s  [STAGES];
  logic             st_c  [STAGES];
  logic [WIDTH-1:0] nx_s  [STAGES];
  logic             nx_c  [STAGES];

  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;
  logic             adv;

  // Global stall: the whole pipe moves only when the head can retire.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage 0 takes the prepared operands; later stages take the previous register.
  always_comb begin
    st_v[0] = in_valid;
    st_a[0] = in_a;
    st_b[0] = (in_sub == OP_SUB) ? ~in_b : in_b;
    st_c[0] = (in_sub == OP_ADD) ? in_cin : 1'b1;
    st_s[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      st_v[k] = v_q[k-1];
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_c[k] = c_q[k-1];
      st_s[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned LO = k * S;

    logic [GPS-1:0] gp;
    logic [GPS-1:0] gg;
    logic [GPS:0]   gc;
    logic [S-1:0]   ssum;

    for (genvar j = 0; j < int'(GPS); j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a   (st_a[k][LO + j*GROUP +: GROUP]),
        .b   (st_b[k][LO + j*GROUP +: GROUP]),
        .cin (gc[j]),
        .sum (ssum[j*GROUP +: GROUP]),
        .p   (gp[j]),
        .g   (gg[j])
      );
    end

    // Group-level lookahead across the slice.
    always_comb begin
      gc[0] = st_c[k];
      for (int j = 0; j < int'(GPS); j++) begin
        gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
    end

    // Merge this stage's finished slice into the travelling sum word.
    assign nx_s[k] = (st_s[k] & ~(WIDTH'({S{1'b1}}) << LO)) | (WIDTH'(ssum) << LO);
    assign nx_c[k] = gc[GPS];
  end

  // MSB-slice stage: signed overflow and optional saturation.
  always_comb begin
    fin_ovf = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) &
              (nx_s[L][WIDTH-1] != st_a[L][WIDTH-1]);
    fin_sum = nx_s[L];
`ifdef CLA_PIPE_SAT_EN
    if (fin_ovf) begin
      fin_sum = st_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Pipeline advance; data only loads behind a valid op so a bubble reaching
  // the last stage leaves out_sum at its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        v_q[k] <= st_v[k];
        if (st_v[k]) begin
          a_q[k] <= st_a[k];
          b_q[k] <= st_b[k];
          c_q[k] <= nx_c[k];
          s_q[k] <= (k == int'(L)) ? fin_sum : nx_s[k];
        end
      end
      if (st_v[L]) begin
        ovf_q <= fin_ovf;
      end
    end
  end

  assign out_valid = v_q[L];
  assign out_sum   = s_q[L];
  assign out_cout  = c_q[L];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, GROUP=4, STAGES=2).
// Directed vectors carry hand-computed wrapped and saturated results; the
// variant matching CLA_PIPE_SAT_EN is pushed at accept and popped by a monitor.
module tb_cla_pipe_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s_wrap;
    logic [W-1:0] s_sat;
    logic         c;
    logic         o;
  } vec_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           accepted = 0;
  logic [W-1:0] last_sum = '0;
  vec_t         vecs [13];
  vec_t         bp   [4];
  vec_t         rv   [3];

  function automatic exp_t mk(input vec_t v);
    exp_t e;
    e.c = v.c;
    e.o = v.o;
`ifdef CLA_PIPE_SAT_EN
    e.s = v.s_sat;
`else
    e.s = v.s_wrap;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present one op and hold it until the DUT accepts it (bounded).
  task automatic issue(input vec_t v);
    int   t = 0;
    logic rdy = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_cin   = v.cin;
    in_sub   = v.sub;
    forever begin
      #3;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 50) break;
      @(negedge clk);
    end
    if (rdy) begin
      sb.push_back(mk(v));
      accepted++;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b", in_ready);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      t++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare every retired result against the scoreboard head.
  always @(negedge clk) begin
    #4;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got=%h/%b/%b exp=none", out_sum, out_cout, out_ovf);
      end else begin
        mon_e = sb.pop_front();
        last_sum = mon_e.s;
        check("result", 64'({out_sum, out_cout, out_ovf}), 64'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int lat;
    //                a             b             cin   sub   wrap          sat           c     o
    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 32'h00000002, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0};
    vecs[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[5]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1};
    vecs[6]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 32'h2345678A, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 1'b1};
    vecs[9]  = '{32'h0000000A, 32'h00000003, 1'b0, 1'b1, 32'h00000007, 32'h00000007, 1'b1, 1'b0};
    vecs[10] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 32'h00000007, 1'b1, 1'b0};
    vecs[11] = '{32'hFFFF0000, 32'h00010000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    bp[0]    = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 32'h00000003, 1'b0, 1'b0};
    bp[1]    = '{32'h00000064, 32'h000000C8, 1'b0, 1'b0, 32'h0000012C, 32'h0000012C, 1'b0, 1'b0};
    bp[2]    = '{32'hF0000000, 32'h10000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    bp[3]    = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 32'h55555555, 32'h80000000, 1'b1, 1'b1};
    rv[0]    = '{32'h00001111, 32'h00002222, 1'b0, 1'b0, 32'h00003333, 32'h00003333, 1'b0, 1'b0};
    rv[1]    = '{32'h00000010, 32'h00000001, 1'b0, 1'b1, 32'h0000000F, 32'h0000000F, 1'b1, 1'b0};
    rv[2]    = '{32'h00000009, 32'h00000001, 1'b0, 1'b0, 32'h0000000A, 32'h0000000A, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, back to back
    foreach (vecs[i]) issue(vecs[i]);
    drain("vec_drain");

    // Output holds while idle
    repeat (3) @(negedge clk);
    #1;
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_sum_hold", 64'(out_sum), 64'(last_sum));

    // Backpressure: 4 ops with the sink stalled for 3 cycles
    @(negedge clk);
    #2 out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        foreach (bp[i]) issue(bp[i]);
      end
      begin
        t = 0;
        while (accepted < 2 && t < 50) begin
          @(posedge clk);
          t++;
        end
        check("bp_fill_timeout", 64'(t >= 50), 64'd0);
        #3;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
          @(negedge clk);
          #1;
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_sum", 64'(out_sum), 64'(mk(bp[0]).s));
        end
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with two ops in flight
    @(negedge clk);
    #2 out_ready = 1'b0;
    issue(rv[0]);
    issue(rv[1]);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum",   64'(out_sum),   64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #2 out_ready = 1'b1;
    issue(rv[2]);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("post_rst_latency", 64'(lat), 64'd2);
    drain("rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
